rv_muldiv_unit: RTL and testbench

- Iterative RV32M-style multiply/divide execution unit, parametrised in XLEN.
- Sits beside the single-cycle ALU in the datapath. The control unit raises start for M-extension instructions and stalls PC/register-file writeback until done.
- Uses shift-add multiplication and restoring division, one bit per cycle, with a fixed latency for every operation.

---
 rtl/rv_muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_muldiv_unit.sv
// rtl/rv_muldiv_unit.sv - iterative RV32M-style multiply/divide unit, one bit per cycle
module rv_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Architectural state
  state_t              state_q;
  logic [2:0]          op_q;
  logic                sign_a_q;
  logic                sign_b_q;
  // opa_q: multiplicand magnitude (mul only)
  logic [XLEN-1:0]     opa_q;
  // opb_q: multiplier magnitude, shifted right each step (mul) / divisor magnitude, static (div)
  logic [XLEN-1:0]     opb_q;
  // acc_q: 2*XLEN product accumulator (mul) / {partial remainder, quotient} (div)
  logic [2*XLEN-1:0]   acc_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [XLEN-1:0]     result_q;

  // Operand conditioning at accept time
  logic                a_signed;
  logic                b_signed;
  logic                sign_a_d;
  logic                sign_b_d;
  logic [XLEN-1:0]     mag_a_d;
  logic [XLEN-1:0]     mag_b_d;

  // Per-step datapath
  logic [XLEN-1:0]     mul_addend;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_acc_d;
  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_diff;
  logic                div_ge;
  logic [XLEN-1:0]     div_rem_d;
  logic [XLEN-1:0]     div_quo_d;
  logic [2*XLEN-1:0]   div_acc_d;

  // Final sign correction and selection
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix;
  logic [XLEN-1:0]     rem_fix;
  logic                quo_neg;
  logic [XLEN-1:0]     result_d;

  // Decide per op which operands are signed, then split them into sign and magnitude
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: begin
        a_signed = 1'b1;
      end
      default: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
    endcase
    sign_a_d = a_signed & a[XLEN-1];
    sign_b_d = b_signed & b[XLEN-1];
    // The most negative value maps onto itself, which is the correct unsigned magnitude
    mag_a_d  = sign_a_d ? -a : a;
    mag_b_d  = sign_b_d ? -b : b;
  end

  // One shift-add multiply step: conditionally add into the upper half, shift the whole accumulator right
  always_comb begin
    mul_addend = opb_q[0] ? opa_q : '0;
    mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    mul_acc_d  = {mul_sum, acc_q[XLEN-1:1]};
  end

  // One restoring divide step: shift {rem, quo} left, trial-subtract, keep if non-negative
  always_comb begin
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    // |difference| stays below 2^XLEN, so bit XLEN is a true sign bit
    div_ge    = ~div_diff[XLEN];
    div_rem_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_quo_d = {acc_q[XLEN-2:0], div_ge};
    div_acc_d = {div_rem_d, div_quo_d};
  end

  // Sign-correct the unsigned core result and pick the half the op asks for
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    // Divide-by-zero keeps the all-ones quotient by never negating it
    quo_neg  = (sign_a_q ^ sign_b_q) && (opb_q != '0);
    quo_fix  = quo_neg ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    result_d = '0;
    case (op_q)
      OP_MUL:                       result_d = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result_d = quo_fix;
      OP_REM, OP_REMU:              result_d = rem_fix;
      default:                      result_d = '0;
    endcase
  end

  // Control FSM and datapath registers: IDLE -> CALC (XLEN steps) -> FIN -> IDLE with done
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q     <= op;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            opa_q    <= mag_a_d;
            opb_q    <= mag_b_d;
            // Divide starts with a cleared remainder and the dividend in the quotient half
            acc_q    <= op[2] ? {{XLEN{1'b0}}, mag_a_d} : '0;
            cnt_q    <= CW'(XLEN - 1);
            busy_q   <= 1'b1;
            state_q  <= S_CALC;
          end
        end
        S_CALC: begin
          if (op_q[2]) begin
            acc_q <= div_acc_d;
          end else begin
            acc_q <= mul_acc_d;
            opb_q <= opb_q >> 1;
          end
          if (cnt_q == '0) begin
            state_q <= S_FIN;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_FIN: begin
          result_q <= result_d;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb/tb_rv_muldiv_unit.sv - self-checking bench for rv_muldiv_unit (XLEN=32 and XLEN=8)
module tb_rv_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  logic        reset8, start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [7:0]  result8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  rv_muldiv_unit #(.XLEN(8)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8)
  );

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] e;
  } vec_t;

  // Reference: RV32M semantics from wide integer arithmetic
  function automatic logic [31:0] model32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, sy, ux, uy, p;
    int si, sj;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    si = x;
    sj = y;
    case (o)
      3'd0: begin p = sx * sy; return p[31:0];  end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return si / sj;
      end
      3'd5: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 32'd0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return si % sj;
      end
      default: begin
        if (y == 32'd0) return x;
        return x % y;
      end
    endcase
  endfunction

  // Drive one request and wait for done; reports latency and cycles where busy was wrong
  task automatic issue32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit same_cycle, output logic [31:0] res, output int lat, output int berr);
    int c;
    berr = 0;
    lat  = -1;
    res  = '0;
    if (!same_cycle) @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    c = 1;
    while (c <= 100) begin
      if (busy !== (c <= 33)) berr++;
      if (done === 1'b1) begin
        lat = c;
        res = result;
        break;
      end
      @(negedge clk);
      c++;
    end
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] res, output int lat, output int berr);
    int c;
    berr = 0;
    lat  = -1;
    res  = '0;
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    c = 1;
    while (c <= 40) begin
      if (busy8 !== (c <= 9)) berr++;
      if (done8 === 1'b1) begin
        lat = c;
        res = result8;
        break;
      end
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    reset8 = 1'b1; start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset8_busy got=%b want=0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset8_done got=%b want=0", done8); end
    total++; if (result8 !== 8'd0) begin bad++; $display("FAIL reset8_result got=%h want=0", result8); end
    reset = 1'b0;
    reset8 = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[$];
    logic [31:0] res;
    int lat, berr;
    v.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
    v.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    v.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    v.push_back('{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF});
    v.push_back('{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780});
    v.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD});
    v.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF});
    v.push_back('{3'd5, 32'd100,       32'd7,         32'd14});
    v.push_back('{3'd7, 32'd100,       32'd7,         32'd2});
    v.push_back('{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001});
    v.push_back('{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF});
    v.push_back('{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF});
    v.push_back('{3'd6, 32'd5,         32'd0,         32'd5});
    v.push_back('{3'd7, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9});
    v.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    v.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
    foreach (v[i]) begin
      issue32(v[i].o, v[i].x, v[i].y, 1'b0, res, lat, berr);
      total++;
      if (res !== v[i].e) begin
        bad++;
        $display("FAIL directed[%0d] op=%0d a=%h b=%h got=%h want=%h", i, v[i].o, v[i].x, v[i].y, res, v[i].e);
      end
      total++;
      if (lat != 34) begin bad++; $display("FAIL directed_latency[%0d] got=%0d want=34", i, lat); end
      total++;
      if (berr != 0) begin bad++; $display("FAIL directed_busy[%0d] wrong_cycles=%0d want=0", i, berr); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y, res, exp_v;
    int lat, berr, sel;
    for (int n = 0; n < 150; n++) begin
      o   = 3'($urandom_range(0, 7));
      x   = $urandom;
      y   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) y = 32'd0;
      if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      if (sel == 2) y = 32'($urandom_range(1, 15));
      if (sel == 3) x = 32'($urandom_range(0, 255));
      if (sel == 4) y = -32'($urandom_range(1, 15));
      exp_v = model32(o, x, y);
      issue32(o, x, y, 1'b0, res, lat, berr);
      total++;
      if (res !== exp_v || lat != 34 || berr != 0) begin
        bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h want=%h lat=%0d busy_err=%0d", n, o, x, y, res, exp_v, lat, berr);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] x, y, exp_v, res_first;
    int first, ndone;
    x = $urandom;
    y = $urandom;
    exp_v = model32(3'd0, x, y);
    first = -1;
    ndone = 0;
    res_first = '0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = x; b = y;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) begin first = c; res_first = result; end
      end
      start = (c == 5 || c == 20);
      a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    end
    start = 1'b0;
    total++; if (ndone != 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", ndone); end
    total++; if (first != 34) begin bad++; $display("FAIL ignore_latency got=%0d want=34", first); end
    total++; if (res_first !== exp_v) begin bad++; $display("FAIL ignore_result got=%h want=%h", res_first, exp_v); end
    total++; if (result !== exp_v) begin bad++; $display("FAIL ignore_result_held got=%h want=%h", result, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  o;
    logic [31:0] x, y, res;
    int lat, berr;
    for (int n = 0; n < 4; n++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      issue32(o, x, y, n != 0, res, lat, berr);
      total++;
      if (res !== model32(o, x, y) || lat != 34 || berr != 0) begin
        bad++;
        $display("FAIL back_to_back[%0d] op=%0d got=%h want=%h lat=%0d busy_err=%0d", n, o, res, model32(o, x, y), lat, berr);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] x, y, res;
    int lat, berr, ndone;
    issue32(3'd5, 32'd100, 32'd7, 1'b0, res, lat, berr);
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = $urandom; b = $urandom;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b want=0", done); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL midreset_result got=%h want=0", result); end
    ndone = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL midreset_stray_done got=%0d want=0", ndone); end
    x = $urandom;
    y = $urandom;
    issue32(3'd3, x, y, 1'b0, res, lat, berr);
    total++;
    if (res !== model32(3'd3, x, y) || lat != 34) begin
      bad++;
      $display("FAIL midreset_mulhu got=%h want=%h lat=%0d", res, model32(3'd3, x, y), lat);
    end
  endtask

  task automatic test_xlen8();
    logic [7:0]  res, x, y;
    logic [15:0] p;
    int lat, berr, ndone;
    issue8(3'd4, 8'h80, 8'hFF, res, lat, berr);
    total++; if (res !== 8'h80 || lat != 10) begin bad++; $display("FAIL x8_div_overflow got=%h want=80 lat=%0d", res, lat); end
    issue8(3'd7, 8'hF9, 8'h00, res, lat, berr);
    total++; if (res !== 8'hF9 || lat != 10) begin bad++; $display("FAIL x8_remu_zero got=%h want=f9 lat=%0d", res, lat); end
    @(negedge clk);
    start8 = 1'b1; op8 = 3'd4; a8 = 8'd77; b8 = 8'd5;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    reset8 = 1'b1;
    @(negedge clk);
    reset8 = 1'b0;
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || result8 !== 8'd0) begin
      bad++;
      $display("FAIL x8_midreset busy=%b done=%b result=%h want=0/0/00", busy8, done8, result8);
    end
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL x8_stray_done got=%0d want=0", ndone); end
    issue8(3'd3, 8'hFF, 8'hFF, res, lat, berr);
    total++; if (res !== 8'hFE) begin bad++; $display("FAIL x8_mulhu got=%h want=fe", res); end
    total++; if (lat != 10 || berr != 0) begin bad++; $display("FAIL x8_latency got=%0d busy_err=%0d want=10/0", lat, berr); end
    for (int n = 0; n < 10; n++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      p = {8'd0, x} * {8'd0, y};
      issue8(3'd3, x, y, res, lat, berr);
      total++;
      if (res !== p[15:8] || lat != 10) begin
        bad++;
        $display("FAIL x8_random_mulhu a=%h b=%h got=%h want=%h lat=%0d", x, y, res, p[15:8], lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_xlen8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
